intc_arbiter: RTL and testbench



---
 rtl/intc_arbiter_pkg.sv | 9 +
 rtl/intc_arbiter_if.sv | 13 +
 rtl/intc_prio_enc.sv | 15 +
 rtl/intc_arbiter.sv | 68 ++++++
 tb/tb_intc_arbiter.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/intc_arbiter_pkg.sv
// intc_arbiter_pkg: shared word type, register map and claim code for the interrupt controller
package intc_arbiter_pkg;
  typedef logic [31:0] word_t;
  localparam logic [1:0] INTC_REG_PENDING = 2'd0;
  localparam logic [1:0] INTC_REG_ENABLE  = 2'd1;
  localparam logic [1:0] INTC_REG_CLAIM   = 2'd2;
  localparam logic [1:0] INTC_REG_EDGE    = 2'd3;
  localparam word_t INTC_NO_IRQ = '0;
endpackage

// File: rtl/intc_arbiter_if.sv
// intc_arbiter_if: interrupt sources plus Avalon-MM slave bundle of the interrupt controller
interface intc_arbiter_if #(parameter int N_IRQ = 8);
  import intc_arbiter_pkg::*;
  logic [N_IRQ-1:0] irq_src;
  logic [1:0] avl_address;
  logic avl_read;
  logic avl_write;
  word_t avl_writedata;
  word_t avl_readdata;
  logic avl_irq;
  modport master (output irq_src, avl_address, avl_read, avl_write, avl_writedata, input avl_readdata, avl_irq);
  modport slave (input irq_src, avl_address, avl_read, avl_write, avl_writedata, output avl_readdata, avl_irq);
endinterface

// File: rtl/intc_prio_enc.sv
// intc_prio_enc: lowest-set-index encoder; idx_o is N when the vector is empty
module intc_prio_enc #(
  parameter int N = 8,
  localparam int W = $clog2(N + 1)
) (
  input  logic [N-1:0] vec_i,
  output logic valid_o,
  output logic [W-1:0] idx_o
);
  always_comb begin
    valid_o = |vec_i;
    idx_o = W'(N);
    for (int i = N - 1; i >= 0; i--) idx_o = vec_i[i] ? W'(i) : idx_o;
  end
endmodule

// File: rtl/intc_arbiter.sv
// intc_arbiter: vectored priority-nesting interrupt controller with claim/complete over Avalon-MM
module intc_arbiter
  import intc_arbiter_pkg::*;
#(
  parameter int N_IRQ = 8
) (
  input logic clk,
  input logic rst,
  intc_arbiter_if.slave bus
);
  localparam int W = $clog2(N_IRQ + 1);
  localparam logic [N_IRQ-1:0] ONE = 1;
  logic [N_IRQ-1:0] sync_q, s_q, s_prev_q, pending_q, pending_d, enable_q, enable_d;
  logic [N_IRQ-1:0] edge_q, edge_d, in_svc_q, in_svc_d;
  logic [N_IRQ-1:0] eligible, rise, claim_mask, w1c_mask, done_mask;
  logic [W-1:0] best, cur;
  logic best_v, cur_v, irq_q, irq_d, rd, wr, claim;
  word_t rdata_q, rdata_d;
  intc_prio_enc #(.N(N_IRQ)) u_best (.vec_i(eligible), .valid_o(best_v), .idx_o(best));
  intc_prio_enc #(.N(N_IRQ)) u_cur (.vec_i(in_svc_q), .valid_o(cur_v), .idx_o(cur));
  // a simultaneous read wins over the write
  always_comb begin
    rd = bus.avl_read;
    wr = bus.avl_write & ~bus.avl_read;
    rise = s_q & ~s_prev_q;
    eligible = pending_q & enable_q & ~in_svc_q;
    irq_d = best_v && (!cur_v || best < cur);
    claim = rd && bus.avl_address == INTC_REG_CLAIM && irq_d;
    claim_mask = claim ? ONE << best : '0;
    w1c_mask = (wr && bus.avl_address == INTC_REG_PENDING) ? bus.avl_writedata[N_IRQ-1:0] : '0;
    done_mask = (wr && bus.avl_address == INTC_REG_CLAIM && bus.avl_writedata != 32'd0 &&
                 bus.avl_writedata <= 32'(N_IRQ)) ? ONE << (bus.avl_writedata - 32'd1) : '0;
    pending_d = (edge_q & ((pending_q & ~(claim_mask | w1c_mask)) | rise)) | (~edge_q & s_q);
    in_svc_d = (in_svc_q | claim_mask) & ~done_mask;
    enable_d = (wr && bus.avl_address == INTC_REG_ENABLE) ? bus.avl_writedata[N_IRQ-1:0] : enable_q;
    edge_d = (wr && bus.avl_address == INTC_REG_EDGE) ? bus.avl_writedata[N_IRQ-1:0] : edge_q;
    rdata_d = !rd ? rdata_q :
              bus.avl_address == INTC_REG_PENDING ? word_t'(pending_q) :
              bus.avl_address == INTC_REG_ENABLE ? word_t'(enable_q) :
              bus.avl_address == INTC_REG_CLAIM ? (irq_d ? word_t'(best) + 32'd1 : INTC_NO_IRQ) :
              word_t'(edge_q);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      s_q <= '0;
      s_prev_q <= '0;
      pending_q <= '0;
      enable_q <= '0;
      edge_q <= '0;
      in_svc_q <= '0;
      rdata_q <= '0;
      irq_q <= 1'b0;
    end else begin
      sync_q <= bus.irq_src;
      s_q <= sync_q;
      s_prev_q <= s_q;
      pending_q <= pending_d;
      enable_q <= enable_d;
      edge_q <= edge_d;
      in_svc_q <= in_svc_d;
      rdata_q <= rdata_d;
      irq_q <= irq_d;
    end
  end
  assign bus.avl_readdata = rdata_q;
  assign bus.avl_irq = irq_q;
endmodule

// File: tb/tb_intc_arbiter.sv
// tb_intc_arbiter: directed register vectors plus hand-written claim/complete/nesting sequences
module tb_intc_arbiter;
  localparam logic [1:0] A_PEND = 2'd0;
  localparam logic [1:0] A_EN = 2'd1;
  localparam logic [1:0] A_CLM = 2'd2;
  localparam logic [1:0] A_EDGE = 2'd3;
  typedef struct {
    logic wr;
    logic [1:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_checks = 0;
  int n_errors = 0;
  vec_t vecs[10];
  logic [31:0] d;
  intc_arbiter_if #(.N_IRQ(8)) bus ();
  intc_arbiter #(.N_IRQ(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic rd_reg(input logic [1:0] a, output logic [31:0] data);
    @(negedge clk);
    bus.avl_address = a;
    bus.avl_read = 1'b1;
    @(negedge clk);
    bus.avl_read = 1'b0;
    data = bus.avl_readdata;
  endtask
  task automatic wr_reg(input logic [1:0] a, input logic [31:0] data);
    @(negedge clk);
    bus.avl_address = a;
    bus.avl_writedata = data;
    bus.avl_write = 1'b1;
    @(negedge clk);
    bus.avl_write = 1'b0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.irq_src = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
  initial begin
    bus.irq_src = '0;
    bus.avl_address = '0;
    bus.avl_read = 1'b0;
    bus.avl_write = 1'b0;
    bus.avl_writedata = '0;
    vecs[0] = '{1'b1, A_EN, 32'hFFFF_FFFF, 32'h0};
    vecs[1] = '{1'b0, A_EN, 32'h0, 32'h0000_00FF};
    vecs[2] = '{1'b1, A_EDGE, 32'h0000_01A5, 32'h0};
    vecs[3] = '{1'b0, A_EDGE, 32'h0, 32'h0000_00A5};
    vecs[4] = '{1'b0, A_PEND, 32'h0, 32'h0};
    vecs[5] = '{1'b0, A_CLM, 32'h0, 32'h0};
    vecs[6] = '{1'b1, A_EN, 32'h0, 32'h0};
    vecs[7] = '{1'b0, A_EN, 32'h0, 32'h0};
    vecs[8] = '{1'b1, A_EDGE, 32'h0, 32'h0};
    vecs[9] = '{1'b0, A_EDGE, 32'h0, 32'h0};
    repeat (2) @(negedge clk);
    chk("reset_irq", 32'(bus.avl_irq), 32'h0);
    chk("reset_rdata", bus.avl_readdata, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].wr) wr_reg(vecs[i].addr, vecs[i].wdata);
      else begin
        rd_reg(vecs[i].addr, d);
        chk($sformatf("vec%0d", i), d, vecs[i].exp);
      end
    end
    // level source: latency, claim, complete with source still high
    do_reset();
    wr_reg(A_EDGE, 32'h0);
    wr_reg(A_EN, 32'h3);
    bus.irq_src = 8'h02;
    repeat (3) @(negedge clk);
    chk("lvl_irq_e2", 32'(bus.avl_irq), 32'h0);
    @(negedge clk);
    chk("lvl_irq_e3", 32'(bus.avl_irq), 32'h1);
    rd_reg(A_CLM, d);
    chk("lvl_claim", d, 32'h2);
    chk("lvl_irq_hold", 32'(bus.avl_irq), 32'h1);
    @(negedge clk);
    chk("lvl_irq_drop", 32'(bus.avl_irq), 32'h0);
    wr_reg(A_CLM, 32'h2);
    chk("lvl_cmp_e0", 32'(bus.avl_irq), 32'h0);
    @(negedge clk);
    chk("lvl_reassert", 32'(bus.avl_irq), 32'h1);
    // edge source: latch, claim clears, re-latch while in service
    do_reset();
    wr_reg(A_EDGE, 32'h1);
    wr_reg(A_EN, 32'h1);
    bus.irq_src = 8'h01;
    repeat (3) @(negedge clk);
    bus.irq_src = 8'h00;
    repeat (3) @(negedge clk);
    rd_reg(A_PEND, d);
    chk("edg_pend", d, 32'h1);
    rd_reg(A_CLM, d);
    chk("edg_claim", d, 32'h1);
    rd_reg(A_PEND, d);
    chk("edg_pend_clr", d, 32'h0);
    bus.irq_src = 8'h01;
    repeat (3) @(negedge clk);
    bus.irq_src = 8'h00;
    repeat (3) @(negedge clk);
    rd_reg(A_PEND, d);
    chk("edg_pend2", d, 32'h1);
    chk("edg_irq_masked", 32'(bus.avl_irq), 32'h0);
    rd_reg(A_CLM, d);
    chk("edg_claim_none", d, 32'h0);
    rd_reg(A_PEND, d);
    chk("edg_pend_kept", d, 32'h1);
    wr_reg(A_CLM, 32'h1);
    @(negedge clk);
    chk("edg_irq_after_cmp", 32'(bus.avl_irq), 32'h1);
    // nesting
    do_reset();
    wr_reg(A_EN, 32'h7);
    bus.irq_src = 8'h04;
    repeat (4) @(negedge clk);
    chk("nest_irq2", 32'(bus.avl_irq), 32'h1);
    rd_reg(A_CLM, d);
    chk("nest_claim2", d, 32'h3);
    bus.irq_src = 8'h05;
    repeat (4) @(negedge clk);
    chk("nest_irq0", 32'(bus.avl_irq), 32'h1);
    rd_reg(A_CLM, d);
    chk("nest_claim0", d, 32'h1);
    bus.irq_src = 8'h07;
    repeat (4) @(negedge clk);
    chk("nest_src1_masked", 32'(bus.avl_irq), 32'h0);
    bus.irq_src = 8'h06;
    repeat (4) @(negedge clk);
    wr_reg(A_CLM, 32'h1);
    @(negedge clk);
    chk("nest_irq1", 32'(bus.avl_irq), 32'h1);
    rd_reg(A_CLM, d);
    chk("nest_claim1", d, 32'h2);
    // W1C coinciding with a rising edge: set wins
    do_reset();
    wr_reg(A_EDGE, 32'h1);
    bus.irq_src = 8'h01;
    repeat (3) @(negedge clk);
    bus.irq_src = 8'h00;
    repeat (3) @(negedge clk);
    rd_reg(A_PEND, d);
    chk("w1c_pre", d, 32'h1);
    bus.irq_src = 8'h01;
    repeat (2) @(negedge clk);
    bus.avl_address = A_PEND;
    bus.avl_writedata = 32'h1;
    bus.avl_write = 1'b1;
    @(negedge clk);
    bus.avl_write = 1'b0;
    bus.irq_src = 8'h00;
    rd_reg(A_PEND, d);
    chk("w1c_vs_rise", d, 32'h1);
    wr_reg(A_PEND, 32'h1);
    rd_reg(A_PEND, d);
    chk("w1c_plain", d, 32'h0);
    // out-of-range and not-in-service COMPLETE codes
    wr_reg(A_EDGE, 32'h0);
    wr_reg(A_EN, 32'h1);
    bus.irq_src = 8'h01;
    repeat (4) @(negedge clk);
    rd_reg(A_CLM, d);
    chk("cmp_claim", d, 32'h1);
    wr_reg(A_CLM, 32'h0);
    wr_reg(A_CLM, 32'h9);
    wr_reg(A_CLM, 32'h2);
    @(negedge clk);
    chk("cmp_bad_codes", 32'(bus.avl_irq), 32'h0);
    wr_reg(A_CLM, 32'h1);
    @(negedge clk);
    chk("cmp_good", 32'(bus.avl_irq), 32'h1);
    // read and write together: read wins
    @(negedge clk);
    bus.avl_address = A_EN;
    bus.avl_writedata = 32'hFF;
    bus.avl_read = 1'b1;
    bus.avl_write = 1'b1;
    @(negedge clk);
    bus.avl_read = 1'b0;
    bus.avl_write = 1'b0;
    chk("rw_rdata", bus.avl_readdata, 32'h1);
    rd_reg(A_EN, d);
    chk("rw_enable", d, 32'h1);
    // reset with a source in service and another pending
    bus.irq_src = 8'h06;
    wr_reg(A_EN, 32'h4);
    repeat (4) @(negedge clk);
    rd_reg(A_CLM, d);
    chk("rst_claim2", d, 32'h3);
    wr_reg(A_EN, 32'h6);
    @(negedge clk);
    chk("rst_pre_irq", 32'(bus.avl_irq), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    bus.irq_src = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_irq", 32'(bus.avl_irq), 32'h0);
    rd_reg(A_PEND, d);
    chk("rst_pend", d, 32'h0);
    rd_reg(A_EN, d);
    chk("rst_en", d, 32'h0);
    rd_reg(A_EDGE, d);
    chk("rst_edge", d, 32'h0);
    wr_reg(A_EN, 32'h4);
    bus.irq_src = 8'h04;
    repeat (4) @(negedge clk);
    chk("rst_insvc_irq", 32'(bus.avl_irq), 32'h1);
    rd_reg(A_CLM, d);
    chk("rst_insvc_claim", d, 32'h3);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
